// File: rtl/mem_write_controller_if.sv
// mem_write_controller_if: bundles the store-path bus between the execute
// stage and mem_write_controller.
//   Execute-stage side (driven into the controller):
//     instruction, mem_addr, store_data, pc, uart_tx_ready, ac_fifo_full
//   Controller side (driven by mem_write_controller):
//     mem_wdata, dmem_we, imem_we, uart_tx_data, uart_tx_valid, counter_rst,
//     leds, ac_fifo_din, ac_fifo_wr_en, mem_stall, misalign_err
// Modports: slave = controller view, master = pipeline/environment view.
interface mem_write_controller_if #(
  parameter int LED_WIDTH = 8
);
  logic [31:0]          instruction;
  logic [31:0]          mem_addr;
  logic [31:0]          store_data;
  logic [31:0]          pc;
  logic [31:0]          mem_wdata;
  logic [3:0]           dmem_we;
  logic [3:0]           imem_we;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_valid;
  logic                 uart_tx_ready;
  logic                 counter_rst;
  logic [LED_WIDTH-1:0] leds;
  logic [31:0]          ac_fifo_din;
  logic                 ac_fifo_wr_en;
  logic                 ac_fifo_full;
  logic                 mem_stall;
  logic                 misalign_err;

  modport slave (
    input  instruction, mem_addr, store_data, pc, uart_tx_ready, ac_fifo_full,
    output mem_wdata, dmem_we, imem_we, uart_tx_data, uart_tx_valid,
           counter_rst, leds, ac_fifo_din, ac_fifo_wr_en, mem_stall, misalign_err
  );

  modport master (
    output instruction, mem_addr, store_data, pc, uart_tx_ready, ac_fifo_full,
    input  mem_wdata, dmem_we, imem_we, uart_tx_data, uart_tx_valid,
           counter_rst, leds, ac_fifo_din, ac_fifo_wr_en, mem_stall, misalign_err
  );
endinterface

// File: rtl/mem_write_controller.sv
// mem_write_controller: store-side memory controller. Decodes the execute-
// stage store, produces byte-lane enables and lane-aligned data for DMEM and
// IMEM, and performs memory-mapped IO writes (posted UART transmit, counter
// reset pulse, LED register, audio FIFO). mem_stall freezes the pipeline when
// an IO write cannot be accepted this cycle.
// Ports:
//   clk  - core clock
//   rst  - synchronous, active-high reset
//   bus  - mem_write_controller_if.slave (see interface file for signal list)
// Optional feature: define MEM_WRITE_MISALIGN_TRAP_EN to suppress misaligned
// SH/SW stores and pulse misalign_err one cycle later; otherwise misaligned
// stores follow the normal lane rules and misalign_err is tied low.
module mem_write_controller #(
  parameter int LED_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  mem_write_controller_if.slave bus
);

  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [2:0]  F3_SB     = 3'b000;
  localparam logic [2:0]  F3_SH     = 3'b001;
  localparam logic [2:0]  F3_SW     = 3'b010;
  localparam logic [11:0] IO_UART   = 12'h008;
  localparam logic [11:0] IO_CNT    = 12'h018;
  localparam logic [11:0] IO_LED    = 12'h030;
  localparam logic [11:0] IO_FIFO   = 12'h044;

  typedef enum logic {S_IDLE, S_BUSY} uart_state_t;

  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [3:0]           w_region;
  logic [1:0]           w_off;
  logic [15:0]          w_hw;
  logic [7:0]           w_byte;
  logic                 w_store;
  logic                 w_store_ok;
  logic [3:0]           w_lane_we;
  logic [31:0]          w_lane_wdata;
  logic                 w_dmem_sel;
  logic                 w_imem_sel;
  logic                 w_io_sel;
  logic                 w_uart_wr;
  logic                 w_cnt_wr;
  logic                 w_led_wr;
  logic                 w_fifo_wr;
  logic                 w_uart_capture;
  logic                 w_uart_stall;
  logic                 w_unused;
  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [7:0]           r_uart_data;
  logic                 r_counter_rst;
  logic [LED_WIDTH-1:0] r_leds;

  assign w_opcode = bus.instruction[6:0];
  assign w_funct3 = bus.instruction[14:12];
  assign w_region = bus.mem_addr[31:28];
  assign w_off    = bus.mem_addr[1:0];
  assign w_hw     = bus.store_data[15:0];
  assign w_byte   = bus.store_data[7:0];
  assign w_store  = (w_opcode == OPC_STORE);

  // Fields of the instruction/PC/address that the store path never looks at.
  assign w_unused = ^{bus.instruction[31:15], bus.instruction[11:7],
                      bus.pc[31], bus.pc[29:0], bus.mem_addr[27:12]};

`ifdef MEM_WRITE_MISALIGN_TRAP_EN
  logic w_misaligned;
  logic r_misalign_err;
  assign w_misaligned = ((w_funct3 == F3_SH) && w_off[0]) ||
                        ((w_funct3 == F3_SW) && (w_off != 2'b00));
  assign w_store_ok   = w_store && !w_misaligned;
  assign bus.misalign_err = r_misalign_err;

  always_ff @(posedge clk) begin
    if (rst) r_misalign_err <= 1'b0;
    else     r_misalign_err <= w_store && w_misaligned;
  end
`else
  assign w_store_ok       = w_store;
  assign bus.misalign_err = 1'b0;
`endif

  // Byte-lane enables and lane-aligned data. SH at offset 3 wraps to the
  // lowest halfword rather than straddling a word boundary.
  always_comb begin
    w_lane_we    = '0;
    w_lane_wdata = '0;
    case (w_funct3)
      F3_SB: begin
        w_lane_we    = 4'b0001 << w_off;
        w_lane_wdata = {4{w_byte}};
      end
      F3_SH: begin
        case (w_off)
          2'd1: begin
            w_lane_we    = 4'b0110;
            w_lane_wdata = {8'h00, w_hw, 8'h00};
          end
          2'd2: begin
            w_lane_we    = 4'b1100;
            w_lane_wdata = {2{w_hw}};
          end
          default: begin
            w_lane_we    = 4'b0011;
            w_lane_wdata = {2{w_hw}};
          end
        endcase
      end
      F3_SW: begin
        w_lane_we    = 4'b1111;
        w_lane_wdata = bus.store_data;
      end
      default: ;
    endcase
  end

  // Region 0011 matches both selects, so it lands in DMEM and IMEM together.
  assign w_dmem_sel = (w_region[3:2] == 2'b00) && w_region[0];
  assign w_imem_sel = (w_region[3:1] == 3'b001) && bus.pc[30];
  assign w_io_sel   = (w_region == 4'b1000);

  assign bus.mem_wdata = w_lane_wdata;
  assign bus.dmem_we   = (w_store_ok && w_dmem_sel) ? w_lane_we : '0;
  assign bus.imem_we   = (w_store_ok && w_imem_sel) ? w_lane_we : '0;

  assign w_uart_wr = w_store_ok && w_io_sel && (bus.mem_addr[11:0] == IO_UART);
  assign w_cnt_wr  = w_store_ok && w_io_sel && (bus.mem_addr[11:0] == IO_CNT);
  assign w_led_wr  = w_store_ok && w_io_sel && (bus.mem_addr[11:0] == IO_LED);
  assign w_fifo_wr = w_store_ok && w_io_sel && (bus.mem_addr[11:0] == IO_FIFO);

  assign bus.ac_fifo_din   = bus.store_data;
  assign bus.ac_fifo_wr_en = w_fifo_wr && !bus.ac_fifo_full;

  // UART FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // UART FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_uart_wr)         w_state_next = S_BUSY;
      S_BUSY: if (bus.uart_tx_ready) w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // UART FSM: outputs. A store arriving while BUSY is held off by the stall
  // and only captured once the FSM has returned to IDLE.
  always_comb begin
    bus.uart_tx_valid = 1'b0;
    w_uart_capture    = 1'b0;
    w_uart_stall      = 1'b0;
    case (r_state)
      S_IDLE: w_uart_capture = w_uart_wr;
      S_BUSY: begin
        bus.uart_tx_valid = 1'b1;
        w_uart_stall      = w_uart_wr;
      end
      default: ;
    endcase
  end

  assign bus.mem_stall = w_uart_stall || (w_fifo_wr && bus.ac_fifo_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uart_data   <= '0;
      r_counter_rst <= 1'b0;
      r_leds        <= '0;
    end else begin
      if (w_uart_capture) r_uart_data <= w_byte;
      r_counter_rst <= w_cnt_wr;
      if (w_led_wr) r_leds <= bus.store_data[LED_WIDTH-1:0];
    end
  end

  assign bus.uart_tx_data = r_uart_data;
  assign bus.counter_rst  = r_counter_rst;
  assign bus.leds         = r_leds;

endmodule
